// File: rtl/shift_sequencer.sv
// Transaction front end for the 32-bit universal shift register Shift_32.
// It parallel-loads a job word, shifts it in_shamt times, captures Q and returns it on a result port.
module shift_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic             in_rot,
    input  logic             in_fill,
    input  logic [CNT_W-1:0] in_shamt,
    output logic             S1,
    output logic             S0,
    output logic             SR,
    output logic             SL,
    output logic [WIDTH-1:0] PData,
    input  logic [WIDTH-1:0] Q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCapture,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dir_q, rot_q, fill_q;
    logic               accept;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q    <= StIdle;
            data_q     <= '0;
            out_data_q <= '0;
            cnt_q      <= '0;
            dir_q      <= 1'b0;
            rot_q      <= 1'b0;
            fill_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                data_q <= in_data;
                dir_q  <= in_dir;
                rot_q  <= in_rot;
                fill_q <= in_fill;
            end
            if (state_q == StCapture) begin
                out_data_q <= Q;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;
        out_valid = 1'b0;
        S1        = 1'b0;
        S0        = 1'b0;
        SR        = 1'b0;
        SL        = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept  = 1'b1;
                    cnt_d   = in_shamt;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                S1      = 1'b1;
                S0      = 1'b1;
                state_d = (cnt_q != '0) ? StShift : StCapture;
            end
            StShift: begin
                // Rotate feeds the outgoing bit straight back from Q in the same cycle.
                if (dir_q) begin
                    S1 = 1'b1;
                    SL = rot_q ? Q[WIDTH-1] : fill_q;
                end else begin
                    S0 = 1'b1;
                    SR = rot_q ? Q[0] : fill_q;
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign PData    = data_q;
    assign out_data = out_data_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer paired with a behavioural Shift_32 register.
`timescale 1ns/1ps
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        clear;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        in_dir, in_rot, in_fill;
    logic [5:0]  in_shamt;
    logic        S1, S0, SR, SL;
    logic [31:0] PData;
    logic [31:0] q_reg = '0;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 clk = ~clk;

    // Shift_32 stand-in: no reset, so contents survive a sequencer reset.
    always @(posedge clk) begin
        case ({S1, S0})
            2'b01:   q_reg <= {SR, q_reg[31:1]};
            2'b10:   q_reg <= {q_reg[30:0], SL};
            2'b11:   q_reg <= PData;
            default: q_reg <= q_reg;
        endcase
    end

    shift_sequencer #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_rot    (in_rot),
        .in_fill   (in_fill),
        .in_shamt  (in_shamt),
        .S1        (S1),
        .S0        (S0),
        .SR        (SR),
        .SL        (SL),
        .PData     (PData),
        .Q         (q_reg),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [31:0] data, input logic dir,
                           input logic rot, input logic fill, input logic [5:0] shamt,
                           input logic [31:0] exp, input int bp);
        int cycles;
        int loads;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = data;
        in_dir   = dir;
        in_rot   = rot;
        in_fill  = fill;
        in_shamt = shamt;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cycles   = 0;
        loads    = 0;
        while (!out_valid && cycles < 200) begin
            if ({S1, S0} == 2'b11) loads++;
            @(posedge clk);
            #1;
            cycles++;
        end
        check({tag, " latency"}, 32'(cycles), 32'(shamt) + 32'd2);
        check({tag, " loads"}, 32'(loads), 32'd1);
        check({tag, " data"}, out_data, exp);
        for (int i = 0; i < bp; i++) begin
            // Competing request while stalled; it must wait for IDLE.
            in_valid = 1'b1;
            in_data  = 32'h0000_0001;
            in_dir   = 1'b1;
            in_rot   = 1'b0;
            in_fill  = 1'b0;
            in_shamt = 6'd3;
            @(posedge clk);
            #1;
            check({tag, " bp valid"}, 32'(out_valid), 32'd1);
            check({tag, " bp data"}, out_data, exp);
            check({tag, " bp in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " bp mode"}, 32'({S1, S0}), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " valid pulse"}, 32'(out_valid), 32'd0);
        check({tag, " idle ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir    = 1'b0;
        in_rot    = 1'b0;
        in_fill   = 1'b0;
        in_shamt  = '0;
        out_ready = 1'b0;

        @(negedge clk);
        check("rst mode", 32'({S1, S0}), 32'd0);
        check("rst serial", 32'({SR, SL}), 32'd0);
        check("rst pdata", PData, 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        clear = 1'b1;

        run_job("shr31",   32'h8000_0000, 1'b0, 1'b0, 1'b0, 6'd31, 32'h0000_0001, 0);
        run_job("shl4f1",  32'hAAAA_AAAA, 1'b1, 1'b0, 1'b1, 6'd4,  32'hAAAA_AAAF, 0);
        run_job("shl40",   32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 6'd40, 32'h0000_0000, 0);
        run_job("shr40f1", 32'h0000_0000, 1'b0, 1'b0, 1'b1, 6'd40, 32'hFFFF_FFFF, 0);
        run_job("rotr1",   32'h0000_0001, 1'b0, 1'b1, 1'b0, 6'd1,  32'h8000_0000, 0);
        run_job("rotl33",  32'h8000_0001, 1'b1, 1'b1, 1'b0, 6'd33, 32'h0000_0003, 0);
        run_job("sh0",     32'h1234_5678, 1'b0, 1'b0, 1'b1, 6'd0,  32'h1234_5678, 0);
        run_job("bp",      32'h0F0F_0000, 1'b0, 1'b0, 1'b0, 6'd4,  32'h00F0_F000, 5);
        run_job("pending", 32'h0000_0001, 1'b1, 1'b0, 1'b0, 6'd3,  32'h0000_0008, 0);

        // Reset in the middle of a 20-cycle shift.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_0000;
        in_dir   = 1'b0;
        in_rot   = 1'b0;
        in_fill  = 1'b0;
        in_shamt = 6'd20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        check("mid busy", 32'(busy), 32'd1);
        check("mid mode", 32'({S1, S0}), 32'd1);
        clear = 1'b0;
        #1;
        check("clr busy", 32'(busy), 32'd0);
        check("clr mode", 32'({S1, S0}), 32'd0);
        check("clr out_valid", 32'(out_valid), 32'd0);
        check("clr in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        clear = 1'b1;

        run_job("after_clr", 32'h0000_000F, 1'b0, 1'b0, 1'b0, 6'd2, 32'h0000_0003, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Upstream control stage for the 32-bit universal shift register `Shift_32`. It accepts a shift job (word, direction, amount, fill/rotate) over a valid/ready handshake and drives the register's mode, serial and parallel inputs: one parallel load, then exactly `shamt` shift cycles. It then captures the register's `Q` and returns it on a valid/ready result port. This turns the free-running shift register into a transaction-level shifter usable by datapath blocks.

## Interface
- `WIDTH`, 32: data width; must match `Shift_32`.
- `CNT_W`, 6: width of shift amount; amounts 0..2^CNT_W-1 are legal.

- `clk`  in  1  rising-edge clock, shared with `Shift_32`.
- `clear`  in  1  reset; one clock, reset is asynchronous and active-low.
- `in_valid`  in  1  job request.
- `in_ready`  out  1  high only in IDLE.
- `in_data`  in  WIDTH  word to load.
- `in_dir`  in  1  0 = shift right (toward bit 0), 1 = shift left.
- `in_rot`  in  1  1 = rotate; the bit shifted out re-enters.
- `in_fill`  in  1  serial fill bit when `in_rot`=0.
- `in_shamt`  in  CNT_W  number of shift cycles.
- `S1`, `S0`  out  1 each  `Shift_32` mode: 00 hold, 01 shift right (`SR` enters bit 31), 10 shift left (`SL` enters bit 0), 11 parallel load.
- `SR`, `SL`  out  1 each  serial inputs to `Shift_32`.
- `PData`  out  WIDTH  parallel load value.
- `Q`  in  WIDTH  `Shift_32` output.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  result consumer ready.
- `out_data`  out  WIDTH  captured result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE, DONE.
- IDLE: `in_ready`=1, mode 00. On `in_valid`&&`in_ready`, latch `in_data`, `in_dir`, `in_rot`, `in_fill` and `in_shamt` into internal registers, then go to LOAD.
- LOAD: mode 11 and `PData` = latched data. Next state is SHIFT if the remaining count is nonzero, else CAPTURE.
- SHIFT: mode 01 (dir=0) or 10 (dir=1). Serial bit:
  - Right: `SR` = `Q[0]` if rotating, else the fill bit.
  - Left: `SL` = `Q[WIDTH-1]` if rotating, else the fill bit.
  - The unused serial input is 0.
  - The remaining count decrements each cycle. When the count is 1, go to CAPTURE.
- CAPTURE: mode 00. Register `out_data` <= `Q` and go to DONE.
- DONE: `out_valid`=1, mode 00, `out_data` stable. On `out_ready`, go to IDLE.
- Outputs `SR`/`SL` for rotate are combinational from `Q`. All other outputs are registered or decoded from state.
- `PData` holds the latched data from acceptance until the next acceptance.
- Amounts >= WIDTH are executed literally (e.g. 40 right shifts with fill=1 gives all-ones; rotating by 33 equals rotating by 1).

## Timing
- Accept edge A. `Shift_32` loads at edge A+1. Shifts occur at edges A+2 .. A+1+N. `out_data` is captured at edge A+2+N. `out_valid` rises after edge A+2+N.
- N=0: load at A+1, capture at A+2.
- Job latency is N+2 cycles to `out_valid`. A new job can be accepted one cycle after the `out_valid`&&`out_ready` edge, giving a minimum period of N+4 cycles.
- `in_valid` while not IDLE is ignored. No queuing; the requester must hold `in_valid`.
- Reset values: `S1`=`S0`=0, `SR`=`SL`=0, `PData`=0, `out_valid`=0, `out_data`=0, `busy`=0, `in_ready`=1, state IDLE, count 0.
- Reset asserted mid-job: the block goes to IDLE immediately (asynchronously) and mode becomes hold. `Shift_32` contents are left as is. No result is produced. The next job reloads the register, so stale contents are harmless.
- `out_ready` held high in DONE: one-cycle `out_valid` pulse.

## Test plan
Bench pairs the block with `Shift_32`, a 20 ns clock, and `clear` low for 2 cycles.
- Right, data 0x80000000, shamt 31, fill 0 -> `out_data` 0x00000001; `out_valid` rises 33 cycles after the accept edge.
- Left, data 0xAAAAAAAA, shamt 4, fill 1 -> 0xAAAAAAAF. Left, data 0x0000FFFF, shamt 40, fill 0 -> 0x00000000.
- Rotate right, data 0x00000001, shamt 1 -> 0x80000000. Rotate left, data 0x80000001, shamt 33 -> 0x00000003.
- shamt 0, data 0x12345678 -> 0x12345678; `out_valid` 2 cycles after accept; `S1S0`=11 for exactly one cycle.
- Backpressure: `out_ready` low for 5 cycles in DONE -> `out_data` and `out_valid` stable, `in_ready`=0. A second `in_valid` during this time is not accepted. It is accepted one cycle after the handshake.
- Deassert `clear` mid-SHIFT (shamt 20, cycle 10) -> same-cycle `busy`=0, `S1S0`=00, `out_valid`=0. A following job with data 0x0000000F, right, shamt 2 -> 0x00000003.
